// File: rtl/ntwrk_pkg.sv
// Shared types and defaults for the top-K network-size product unit.
package ntwrk_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        MULT,
        OUT
    } state_t;

    localparam int NUM_POINTS_DEF = 1000;
    localparam int NUM_NTWRKS_DEF = 3;

    // Size width must be able to hold the value num_points itself.
    function automatic int sz_width(input int num_points);
        return $clog2(num_points) + 1;
    endfunction

endpackage

// File: rtl/ntwrk_prod_topk_insert.sv
// Sorted register array of the NUM_NTWRKS largest sizes; one descending
// insert per cycle, equal values land below existing entries.
module topk_insert #(
    parameter int NUM_NTWRKS = 3,
    parameter int SZ_W       = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    input  logic                                ins_vld,
    input  logic [SZ_W-1:0]                     ins_val,
    output logic [NUM_NTWRKS-1:0][SZ_W-1:0]     top
);

    logic [NUM_NTWRKS-1:0]              keep;
    logic [NUM_NTWRKS-1:0][SZ_W-1:0]    top_nxt;

    // keep[] is a run of ones from slot 0; the first zero is the insert point.
    for (genvar i = 0; i < NUM_NTWRKS; i++) begin : g_slot
        assign keep[i] = (top[i] >= ins_val);
        if (i == 0) begin : g_head
            assign top_nxt[i] = keep[i] ? top[i] : ins_val;
        end else begin : g_tail
            assign top_nxt[i] = keep[i]   ? top[i]  :
                                keep[i-1] ? ins_val : top[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            top <= '0;
        end else if (ins_vld) begin
            top <= top_nxt;
        end
    end

endmodule

// File: rtl/ntwrk_prod.sv
// Top-K network-size product: collect sizes, multiply the K largest one
// factor per cycle, hold the answer until accepted. NTWRK_PROD_SAT_EN enables saturation.
module ntwrk_prod
    import ntwrk_pkg::*;
#(
    parameter int NUM_POINTS = NUM_POINTS_DEF,
    parameter int NUM_NTWRKS = NUM_NTWRKS_DEF,
    parameter int SZ_W       = sz_width(NUM_POINTS),
    parameter int PROD_W     = SZ_W * NUM_NTWRKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SZ_W-1:0]   sz_in,
    input  logic              sz_vld,
    input  logic              sz_last,
    output logic              sz_rdy,
    output logic [PROD_W-1:0] answer,
    output logic              answer_vld,
    input  logic              answer_rdy,
    output logic              ovf,
    output logic              busy
);

    localparam int              CNT_W  = (NUM_NTWRKS < 1) ? 1 : $clog2(NUM_NTWRKS + 1);
    localparam logic [SZ_W-1:0] MAX_SZ = SZ_W'(NUM_POINTS);

    state_t                             state, state_nxt;
    logic [NUM_NTWRKS-1:0][SZ_W-1:0]    top;
    logic [PROD_W-1:0]                  acc;
    logic [CNT_W-1:0]                   cnt;
    logic                               accept;
    logic                               ins_vld;
    logic                               clr;
    logic [SZ_W-1:0]                    fac;
    logic [SZ_W-1:0]                    fac_eff;

    assign accept  = sz_vld && (state == COLLECT);
    assign ins_vld = accept && (sz_in != '0) && (sz_in <= MAX_SZ);
    assign clr     = (state == OUT) && answer_rdy;

    topk_insert #(
        .NUM_NTWRKS (NUM_NTWRKS),
        .SZ_W       (SZ_W)
    ) u_topk (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .ins_vld (ins_vld),
        .ins_val (sz_in),
        .top     (top)
    );

    // cnt==0 is the entry cycle; cnt==i+1 multiplies by slot i.
    always_comb begin
        fac = '0;
        for (int i = 0; i < NUM_NTWRKS; i++) begin
            if (cnt == CNT_W'(i + 1)) begin
                fac = top[i];
            end
        end
    end

    assign fac_eff = (fac == '0) ? SZ_W'(1) : fac;

`ifdef NTWRK_PROD_SAT_EN
    logic                       ovf_q;
    logic [PROD_W+SZ_W-1:0]     prod_full;

    assign prod_full = {{SZ_W{1'b0}}, acc} * {{PROD_W{1'b0}}, fac_eff};

    function automatic logic prod_ovf(input logic [PROD_W+SZ_W-1:0] p);
        return (p[PROD_W+SZ_W-1:PROD_W] != '0);
    endfunction

    function automatic logic [PROD_W-1:0] prod_sat(input logic [PROD_W+SZ_W-1:0] p,
                                                   input logic                   sticky);
        return (sticky || prod_ovf(p)) ? {PROD_W{1'b1}} : p[PROD_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == MULT && cnt != '0 && prod_ovf(prod_full)) begin
            ovf_q <= 1'b1;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    logic [PROD_W-1:0]          prod_wrap;

    assign prod_wrap = acc * PROD_W'(fac_eff);
    assign ovf       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && sz_last)                state_nxt = MULT;
            MULT:    if (cnt == CNT_W'(NUM_NTWRKS))        state_nxt = OUT;
            OUT:     if (answer_rdy)                       state_nxt = COLLECT;
            default:                                       state_nxt = COLLECT;
        endcase
    end

    // An empty array forces a zero seed so the answer stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                COLLECT: cnt <= '0;
                MULT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) begin
                        acc <= (top[0] == '0) ? '0 : PROD_W'(1);
                    end else begin
`ifdef NTWRK_PROD_SAT_EN
                        acc <= prod_sat(prod_full, ovf_q);
`else
                        acc <= prod_wrap;
`endif
                    end
                end
                OUT: if (answer_rdy) acc <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    assign sz_rdy     = (state == COLLECT);
    assign answer_vld = (state == OUT);
    assign busy       = (state == MULT) || (state == OUT);
    assign answer     = acc;

endmodule

// File: tb/tb_ntwrk_prod.sv
// Randomized bench for ntwrk_prod: default instance plus a narrow K=2 instance for overflow.
module tb_ntwrk_prod;

    localparam int NP    = 1000;
    localparam int K     = 3;
    localparam int SZW   = 11;
    localparam int PW    = 33;
    localparam int S_NP  = 15;
    localparam int S_K   = 2;
    localparam int S_SZW = 4;
    localparam int S_PW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           sel;
    logic [SZW-1:0] sz_in_t;
    logic           sz_vld_t, sz_last_t, answer_rdy_t;

    logic           m_sz_rdy, m_answer_vld, m_ovf, m_busy;
    logic [PW-1:0]  m_answer;
    logic           s_sz_rdy, s_answer_vld, s_ovf, s_busy;
    logic [S_PW-1:0] s_answer;

    ntwrk_prod u_dut (
        .clk        (clk),
        .rst        (rst),
        .sz_in      (sz_in_t),
        .sz_vld     (sz_vld_t && !sel),
        .sz_last    (sz_last_t),
        .sz_rdy     (m_sz_rdy),
        .answer     (m_answer),
        .answer_vld (m_answer_vld),
        .answer_rdy (answer_rdy_t && !sel),
        .ovf        (m_ovf),
        .busy       (m_busy)
    );

    ntwrk_prod #(
        .NUM_POINTS (S_NP),
        .NUM_NTWRKS (S_K),
        .SZ_W       (S_SZW),
        .PROD_W     (S_PW)
    ) u_small (
        .clk        (clk),
        .rst        (rst),
        .sz_in      (sz_in_t[S_SZW-1:0]),
        .sz_vld     (sz_vld_t && sel),
        .sz_last    (sz_last_t),
        .sz_rdy     (s_sz_rdy),
        .answer     (s_answer),
        .answer_vld (s_answer_vld),
        .answer_rdy (answer_rdy_t && sel),
        .ovf        (s_ovf),
        .busy       (s_busy)
    );

    wire [63:0] o_answer     = sel ? 64'(s_answer) : 64'(m_answer);
    wire        o_answer_vld = sel ? s_answer_vld : m_answer_vld;
    wire        o_sz_rdy     = sel ? s_sz_rdy : m_sz_rdy;
    wire        o_ovf        = sel ? s_ovf : m_ovf;
    wire        o_busy       = sel ? s_busy : m_busy;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %0d, expected %0d", tag, sel, obs, exp);
        end
    endtask

    function automatic int cur_k();
        return sel ? S_K : K;
    endfunction

    // Reference: keep legal sizes, sort descending, multiply the first K.
    function automatic void model(input int q[$], output longint ans, output bit ov);
        int     f[$];
        longint p, lim;
        int     np, pw;
        np  = sel ? S_NP : NP;
        pw  = sel ? S_PW : PW;
        lim = longint'(1) << pw;
        foreach (q[i]) if (q[i] > 0 && q[i] <= np) f.push_back(q[i]);
        f.rsort();
        ov = 1'b0;
        if (f.size() == 0) begin
            ans = 0;
        end else begin
            p = 1;
            for (int i = 0; i < cur_k() && i < f.size(); i++) p = p * f[i];
`ifdef NTWRK_PROD_SAT_EN
            ov  = (p >= lim);
            ans = ov ? lim - 1 : p;
`else
            ans = p % lim;
`endif
        end
    endfunction

    // Called at a negedge in COLLECT; returns at a negedge back in COLLECT.
    task automatic run_set(input int q[$], input int stall);
        longint      ea;
        bit          eo;
        int          lat;
        logic [63:0] held;
        model(q, ea, eo);
        foreach (q[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                sz_vld_t  = 1'b0;
                sz_last_t = 1'($urandom_range(0, 1));
                sz_in_t   = SZW'($urandom_range(1, 15));
                @(negedge clk);
            end
            chk("sz_rdy_collect", o_sz_rdy, 1);
            sz_in_t   = SZW'(q[i]);
            sz_vld_t  = 1'b1;
            sz_last_t = (i == q.size() - 1);
            @(negedge clk);
        end
        sz_vld_t  = 1'b0;
        sz_last_t = 1'b0;
        chk("busy_rise", o_busy, 1);
        chk("sz_rdy_mult", o_sz_rdy, 0);
        lat = 0;
        while (!o_answer_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, cur_k() + 1);
        chk("answer", o_answer, ea);
        chk("ovf", o_ovf, eo);
        held = o_answer;
        for (int s = 0; s < stall; s++) begin
            sz_vld_t = 1'b1;
            sz_in_t  = SZW'($urandom_range(1, 15));
            @(negedge clk);
            chk("stall_answer", o_answer, held);
            chk("stall_vld", o_answer_vld, 1);
            chk("stall_sz_rdy", o_sz_rdy, 0);
        end
        sz_vld_t     = 1'b0;
        answer_rdy_t = 1'b1;
        @(negedge clk);
        answer_rdy_t = 1'b0;
        chk("busy_fall", o_busy, 0);
        chk("sz_rdy_back", o_sz_rdy, 1);
        chk("answer_vld_clr", o_answer_vld, 0);
        chk("answer_clr", o_answer, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sz_rdy"}, o_sz_rdy, 1);
        chk({tag, "_answer"}, o_answer, 0);
        chk({tag, "_answer_vld"}, o_answer_vld, 0);
        chk({tag, "_ovf"}, o_ovf, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    int q[$];

    initial begin
        rst          = 1'b1;
        sel          = 1'b0;
        sz_in_t      = '0;
        sz_vld_t     = 1'b0;
        sz_last_t    = 1'b0;
        answer_rdy_t = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        sel = 1'b1;
        check_idle("reset");
        sel = 1'b0;

        q = '{5, 2, 9, 4, 9};   run_set(q, 0);
        q = '{7, 3};            run_set(q, 0);
        q = '{0};               run_set(q, 1);
        q = '{0, 1001, 6};      run_set(q, 0);
        q = '{1000, 999, 998};  run_set(q, 2);
        q = '{4, 5};            run_set(q, 10);
        q = '{3, 3};            run_set(q, 0);

        // Reset in the middle of MULT.
        sz_in_t = SZW'(5); sz_vld_t = 1'b1; sz_last_t = 1'b0;
        @(negedge clk);
        sz_in_t = SZW'(7); sz_last_t = 1'b1;
        @(negedge clk);
        sz_vld_t = 1'b0; sz_last_t = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mult_rst");
        q = '{2, 3};            run_set(q, 0);

        for (int t = 0; t < 25; t++) begin
            int n, r;
            q.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                r = $urandom_range(0, 9);
                q.push_back(r == 0 ? 0 : r == 1 ? int'($urandom_range(NP + 1, 2047))
                                               : int'($urandom_range(1, NP)));
            end
            run_set(q, $urandom_range(0, 3));
        end

        sel = 1'b1;
        q = '{8, 8};            run_set(q, 1);
        q = '{3, 2};            run_set(q, 0);
        for (int t = 0; t < 10; t++) begin
            int n;
            q.delete();
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) q.push_back(int'($urandom_range(0, 15)));
            run_set(q, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
